fetch_blk_gen: RTL and testbench

//  Fetch stages F1/F2, directly upstream of the instruction buffer. F1 drives the next fetch PC to the I-cache.
//  F2 takes the 8-instruction (32-byte) block returned one cycle later and builds the per-slot valid mask.

---
 rtl/fetch_blk_gen.sv | 180 ++++++++++++++++++
 tb/tb_fetch_blk_gen.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_blk_gen.sv
// Fetch stages F1/F2: F1 issues the next I-cache block address, F2 qualifies the
// returned 8-slot block with a valid mask and redirects on branches, misses, replays and flushes.
module fetch_blk_gen #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         flush_rt_i,
  input  logic [63:0]  redirect_pc_i,
  output logic         icache_req_o,
  output logic [63:0]  icache_addr_o,
  input  logic         icache_hit_i,
  input  logic [255:0] icache_data_i,
  output logic         icache_miss_o,
  output logic [63:0]  icache_miss_addr_o,
  input  logic         icache_fill_i,
  input  logic         inst_q_full_i,
  output logic [31:0]  inst0_o,
  output logic [31:0]  inst1_o,
  output logic [31:0]  inst2_o,
  output logic [31:0]  inst3_o,
  output logic [31:0]  inst4_o,
  output logic [31:0]  inst5_o,
  output logic [31:0]  inst6_o,
  output logic [31:0]  inst7_o,
  output logic [7:0]   inst_vld_o,
  output logic [63:0]  pc_f2_o,
  output logic [1:0]   dbg_state_o
);

  // Handshakes: icache_req_o is a fire-and-forget request answered by icache_hit_i one
  // cycle later; a block moves to the instruction buffer in any cycle where inst_vld_o is
  // non-zero (valid) and inst_q_full_i is low (ready) -- inst_vld_o is already gated by ready.

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MISS     = 2'd1,
    ST_WAIT_IND = 2'd2
  } state_e;

  state_e      state_q, state_d;
  // PCs are kept as word addresses; byte bits [1:0] never matter.
  logic [63:2] pc_f1_q, pc_f1_d;
  logic [63:2] pc_f2_q, pc_f2_d;
  logic        f2_vld_q, f2_vld_d;

  logic [7:0][31:0] slot;
  logic [7:0]  base_mask;
  logic [7:0]  stop_vec;
  logic [7:0]  trunc_mask;
  logic [7:0]  blk_mask;
  logic [2:0]  stop_idx;
  logic        stop_found;
  logic        stop_is_jmp;
  logic [63:2] branch_target;

  logic        f2_miss;
  logic        f2_replay;
  logic        accept;
  logic        take_redir;
  logic        kill;
  logic        unused_pc_bits;

  function automatic logic is_stop_op(input logic [5:0] op);
    return (op == 6'h30) || (op == 6'h34) || (op == 6'h1A);
  endfunction

  assign slot = icache_data_i;
  assign unused_pc_bits = ^redirect_pc_i[1:0];

  // Slots before the fetch offset belong to an earlier path and never count.
  always_comb begin
    base_mask = 8'hFF << pc_f2_q[4:2];
    for (int k = 0; k < 8; k++) begin
      stop_vec[k] = base_mask[k] && is_stop_op(slot[k][31:26]);
    end
  end

  always_comb begin
    stop_found = 1'b0;
    stop_idx   = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (stop_vec[k]) begin
        stop_found = 1'b1;
        stop_idx   = 3'(k);
      end
    end
  end

  assign trunc_mask  = stop_found ? (8'hFF >> (3'd7 - stop_idx)) : 8'hFF;
  assign blk_mask    = base_mask & trunc_mask;
  assign stop_is_jmp = (slot[stop_idx][31:26] == 6'h1A);

  // Word arithmetic: block base + slot index + 1 + sign-extended displacement.
  assign branch_target = {pc_f2_q[63:5], 3'b000}
                       + {59'd0, stop_idx}
                       + 62'd1
                       + {{41{slot[stop_idx][20]}}, slot[stop_idx][20:0]};

  assign f2_miss    = f2_vld_q && !icache_hit_i;
  assign f2_replay  = f2_vld_q && icache_hit_i && inst_q_full_i;
  assign accept     = f2_vld_q && icache_hit_i && !inst_q_full_i && !flush_rt_i;
  assign take_redir = accept && stop_found;
  assign kill       = flush_rt_i || f2_miss || f2_replay || take_redir;

  assign icache_req_o       = reset_n && (state_q == ST_RUN) && !kill;
  assign icache_addr_o      = {pc_f1_q[63:5], 5'b0};
  assign icache_miss_o      = (state_q == ST_MISS);
  assign icache_miss_addr_o = icache_miss_o ? {pc_f2_q[63:5], 5'b0} : 64'h0;
  assign inst_vld_o         = accept ? blk_mask : 8'h00;
  assign pc_f2_o            = {pc_f2_q[63:5], 5'b0};
  assign dbg_state_o        = state_q;

  assign inst0_o = slot[0];
  assign inst1_o = slot[1];
  assign inst2_o = slot[2];
  assign inst3_o = slot[3];
  assign inst4_o = slot[4];
  assign inst5_o = slot[5];
  assign inst6_o = slot[6];
  assign inst7_o = slot[7];

  always_comb begin
    state_d  = state_q;
    pc_f1_d  = pc_f1_q;
    pc_f2_d  = pc_f2_q;
    f2_vld_d = 1'b0;
    if (flush_rt_i) begin
      pc_f1_d = redirect_pc_i[63:2];
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (f2_miss) begin
            state_d = ST_MISS;
          end else if (f2_replay) begin
            pc_f1_d = pc_f2_q;
          end else if (take_redir) begin
            if (stop_is_jmp) begin
              state_d = ST_WAIT_IND;
            end else begin
              pc_f1_d = branch_target;
            end
          end else begin
            pc_f2_d  = pc_f1_q;
            f2_vld_d = 1'b1;
            pc_f1_d  = {pc_f1_q[63:5] + 59'd1, 3'b000};
          end
        end
        ST_MISS: begin
          if (icache_fill_i) begin
            pc_f1_d = pc_f2_q;
            state_d = ST_RUN;
          end
        end
        ST_WAIT_IND: begin
          state_d = ST_WAIT_IND;
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_RUN;
      pc_f1_q  <= RESET_PC[63:2];
      pc_f2_q  <= '0;
      f2_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_f1_q  <= pc_f1_d;
      pc_f2_q  <= pc_f2_d;
      f2_vld_q <= f2_vld_d;
    end
  end

endmodule

// File: tb/tb_fetch_blk_gen.sv
// Bench for fetch_blk_gen: directed scenarios with literal expectations, then random
// traffic checked every cycle against a behavioural fetch model.
module tb_fetch_blk_gen;

  localparam logic [63:0] RST_PC = 64'h1000;
  localparam int M_RUN  = 0;
  localparam int M_MISS = 1;
  localparam int M_WAIT = 2;

  logic         clock;
  logic         reset_n;
  logic         flush_rt_i;
  logic [63:0]  redirect_pc_i;
  logic         icache_req_o;
  logic [63:0]  icache_addr_o;
  logic         icache_hit_i;
  logic [255:0] icache_data_i;
  logic         icache_miss_o;
  logic [63:0]  icache_miss_addr_o;
  logic         icache_fill_i;
  logic         inst_q_full_i;
  logic [31:0]  inst0_o, inst1_o, inst2_o, inst3_o, inst4_o, inst5_o, inst6_o, inst7_o;
  logic [7:0]   inst_vld_o;
  logic [63:0]  pc_f2_o;
  logic [1:0]   dbg_state_o;
  logic [31:0]  dut_inst [8];

  int checks = 0;
  int failures = 0;

  // Scoreboard of blocks the model says must be handed to the buffer: {block_pc, mask}.
  logic [71:0] exp_q[$];

  // Behavioural model state.
  int          m_mode, n_mode;
  logic [63:0] m_f1, n_f1;
  logic [63:0] m_f2, n_f2;
  logic        m_live, n_live;

  fetch_blk_gen #(.RESET_PC(RST_PC)) dut (
    .clock(clock), .reset_n(reset_n), .flush_rt_i(flush_rt_i), .redirect_pc_i(redirect_pc_i),
    .icache_req_o(icache_req_o), .icache_addr_o(icache_addr_o), .icache_hit_i(icache_hit_i),
    .icache_data_i(icache_data_i), .icache_miss_o(icache_miss_o),
    .icache_miss_addr_o(icache_miss_addr_o), .icache_fill_i(icache_fill_i),
    .inst_q_full_i(inst_q_full_i),
    .inst0_o(inst0_o), .inst1_o(inst1_o), .inst2_o(inst2_o), .inst3_o(inst3_o),
    .inst4_o(inst4_o), .inst5_o(inst5_o), .inst6_o(inst6_o), .inst7_o(inst7_o),
    .inst_vld_o(inst_vld_o), .pc_f2_o(pc_f2_o), .dbg_state_o(dbg_state_o)
  );

  assign dut_inst[0] = inst0_o;
  assign dut_inst[1] = inst1_o;
  assign dut_inst[2] = inst2_o;
  assign dut_inst[3] = inst3_o;
  assign dut_inst[4] = inst4_o;
  assign dut_inst[5] = inst5_o;
  assign dut_inst[6] = inst6_o;
  assign dut_inst[7] = inst7_o;

  // ---------------- clock ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, exp);
    end
  endtask

  function automatic logic is_stop(input logic [31:0] w);
    return (w[31:26] == 6'h30) || (w[31:26] == 6'h34) || (w[31:26] == 6'h1A);
  endfunction

  // Model: evaluate expected outputs for the current inputs and compute the next model state.
  task automatic model_eval();
    logic [7:0]  mask;
    int          stop;
    logic [31:0] w;
    logic        deliver;
    logic        e_req;
    logic [63:0] blk_base;
    logic signed [63:0] disp;
    logic [71:0] exp_blk;
    if (!reset_n) begin
      m_mode = M_RUN; m_f1 = RST_PC; m_f2 = 64'h0; m_live = 1'b0;
    end
    blk_base = {m_f2[63:5], 5'b0};
    deliver  = reset_n && m_live && icache_hit_i && !inst_q_full_i && !flush_rt_i;
    mask = 8'h00;
    stop = -1;
    for (int k = int'(m_f2[4:2]); k < 8; k++) begin
      w = icache_data_i[32*k +: 32];
      mask[k] = 1'b1;
      if (is_stop(w)) begin
        stop = k;
        break;
      end
    end
    e_req = reset_n && (m_mode == M_RUN) && !flush_rt_i && !(m_live && !icache_hit_i)
            && !(m_live && inst_q_full_i) && !(deliver && stop >= 0);

    chk("req", 72'(icache_req_o), 72'(e_req));
    chk("addr", 72'(icache_addr_o), 72'({m_f1[63:5], 5'b0}));
    chk("miss", 72'(icache_miss_o), 72'(m_mode == M_MISS));
    chk("miss_addr", 72'(icache_miss_addr_o), 72'((m_mode == M_MISS) ? blk_base : 64'h0));
    chk("pc_f2", 72'(pc_f2_o), 72'(blk_base));
    chk("state", 72'(dbg_state_o), 72'(m_mode));
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("inst%0d", k), 72'(dut_inst[k]), 72'(icache_data_i[32*k +: 32]));
    end

    if (deliver) exp_q.push_back({blk_base, mask});
    if (inst_vld_o != 8'h00 || exp_q.size() != 0) begin
      exp_blk = (exp_q.size() != 0) ? exp_q.pop_front() : 72'h0;
      chk("blk_out", {pc_f2_o, inst_vld_o}, exp_blk);
    end

    n_mode = m_mode; n_f1 = m_f1; n_f2 = m_f2; n_live = 1'b0;
    if (!reset_n) begin
      n_mode = M_RUN; n_f1 = RST_PC; n_f2 = 64'h0;
    end else if (flush_rt_i) begin
      n_f1 = redirect_pc_i; n_mode = M_RUN;
    end else if (m_mode == M_MISS) begin
      if (icache_fill_i) begin
        n_f1 = m_f2; n_mode = M_RUN;
      end
    end else if (m_mode == M_RUN) begin
      if (m_live && !icache_hit_i) begin
        n_mode = M_MISS;
      end else if (m_live && inst_q_full_i) begin
        n_f1 = m_f2;
      end else if (deliver && stop >= 0) begin
        w = icache_data_i[32*stop +: 32];
        if (w[31:26] == 6'h1A) begin
          n_mode = M_WAIT;
        end else begin
          disp = $signed(w[20:0]);
          n_f1 = blk_base + 64'(4 * stop) + 64'd4 + disp * 4;
        end
      end else begin
        n_f2 = m_f1; n_live = 1'b1;
        n_f1 = {m_f1[63:5], 5'b0} + 64'd32;
      end
    end
  endtask

  // Compare process: check on the falling edge, advance the model on the rising edge.
  initial begin
    forever begin
      @(negedge clock);
      model_eval();
      @(posedge clock);
      m_mode = n_mode; m_f1 = n_f1; m_f2 = n_f2; m_live = n_live;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic sample();
    @(negedge clock);
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    flush_rt_i = 1'b0; icache_hit_i = 1'b1; icache_fill_i = 1'b0;
    inst_q_full_i = 1'b0; icache_data_i = '0;
  endtask

  task automatic flush_to(input logic [63:0] pc);
    flush_rt_i = 1'b1; redirect_pc_i = pc;
    sample();
    chk("flush_req", 72'(icache_req_o), 72'(0));
    chk("flush_vld", 72'(inst_vld_o), 72'(0));
    next_cycle();
    flush_rt_i = 1'b0;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 31))
      0: w[31:26] = 6'h30;
      1: w[31:26] = 6'h34;
      2: w[31:26] = 6'h1A;
      default: ;
    endcase
    return w;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0;
    redirect_pc_i = 64'h0;
    idle_inputs();
    sample();
    chk("rst_req", 72'(icache_req_o), 72'(0));
    chk("rst_vld", 72'(inst_vld_o), 72'(0));
    chk("rst_miss", 72'(icache_miss_o), 72'(0));
    chk("rst_pc_f2", 72'(pc_f2_o), 72'(0));
    next_cycle();
    sample();
    next_cycle();
    reset_n = 1'b1;

    // Sequential fetch from the reset PC.
    sample(); chk("t1_addr0", 72'(icache_addr_o), 72'(64'h1000)); chk("t1_req0", 72'(icache_req_o), 72'(1));
    next_cycle();
    sample(); chk("t1_addr1", 72'(icache_addr_o), 72'(64'h1020)); chk("t1_vld1", 72'(inst_vld_o), 72'(8'hFF));
    next_cycle();
    sample(); chk("t1_addr2", 72'(icache_addr_o), 72'(64'h1040)); chk("t1_vld2", 72'(inst_vld_o), 72'(8'hFF));
    next_cycle();

    // Redirect to an unaligned PC.
    flush_to(64'h200C);
    sample(); chk("t2_addr", 72'(icache_addr_o), 72'(64'h2000));
    next_cycle();
    sample(); chk("t2_vld0", 72'(inst_vld_o), 72'(8'hF8)); chk("t2_pc0", 72'(pc_f2_o), 72'(64'h2000));
    next_cycle();
    sample(); chk("t2_vld1", 72'(inst_vld_o), 72'(8'hFF)); chk("t2_pc1", 72'(pc_f2_o), 72'(64'h2020));
    next_cycle();

    // Backward BR in slot 2.
    flush_to(64'h3000);
    sample(); chk("t3_addr", 72'(icache_addr_o), 72'(64'h3000));
    next_cycle();
    icache_data_i[95:64] = 32'hC01FFFFE;
    sample(); chk("t3_vld", 72'(inst_vld_o), 72'(8'h07)); chk("t3_bubble", 72'(icache_req_o), 72'(0));
    next_cycle();
    icache_data_i = '0;
    sample(); chk("t3_tgt", 72'(icache_addr_o), 72'(64'h3000)); chk("t3_req", 72'(icache_req_o), 72'(1));
    next_cycle();
    sample(); chk("t3_vld2", 72'(inst_vld_o), 72'(8'hFE));
    next_cycle();

    // Miss and fill.
    flush_to(64'h4000);
    sample(); chk("t4_addr", 72'(icache_addr_o), 72'(64'h4000));
    next_cycle();
    icache_hit_i = 1'b0;
    sample(); chk("t4_vld", 72'(inst_vld_o), 72'(0)); chk("t4_req", 72'(icache_req_o), 72'(0));
    next_cycle();
    icache_hit_i = 1'b1;
    sample(); chk("t4_miss", 72'(icache_miss_o), 72'(1)); chk("t4_maddr", 72'(icache_miss_addr_o), 72'(64'h4000));
    chk("t4_noreq", 72'(icache_req_o), 72'(0));
    next_cycle();
    icache_fill_i = 1'b1;
    sample(); chk("t4_fill_req", 72'(icache_req_o), 72'(0));
    next_cycle();
    icache_fill_i = 1'b0;
    sample(); chk("t4_refetch", 72'(icache_addr_o), 72'(64'h4000)); chk("t4_req2", 72'(icache_req_o), 72'(1));
    next_cycle();
    sample(); chk("t4_vld2", 72'(inst_vld_o), 72'(8'hFF));
    next_cycle();

    // Buffer full for three cycles.
    flush_to(64'h5000);
    sample(); next_cycle();
    inst_q_full_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample(); chk("t5_vld_full", 72'(inst_vld_o), 72'(0));
      next_cycle();
    end
    inst_q_full_i = 1'b0;
    sample(); chk("t5_replay", 72'(icache_addr_o), 72'(64'h5000));
    next_cycle();
    sample(); chk("t5_vld", 72'(inst_vld_o), 72'(8'hFF)); chk("t5_pc", 72'(pc_f2_o), 72'(64'h5000));
    next_cycle();
    sample(); chk("t5_pc_next", 72'(pc_f2_o), 72'(64'h5020));
    next_cycle();

    // JMP in slot 5, then flush+fill together.
    flush_to(64'h6000);
    sample(); next_cycle();
    icache_data_i[191:160] = 32'h68000000;
    sample(); chk("t6_vld", 72'(inst_vld_o), 72'(8'h3F)); chk("t6_req", 72'(icache_req_o), 72'(0));
    next_cycle();
    icache_data_i = '0;
    sample(); chk("t6_wait", 72'(dbg_state_o), 72'(2)); chk("t6_noreq", 72'(icache_req_o), 72'(0));
    next_cycle();
    flush_rt_i = 1'b1; icache_fill_i = 1'b1; redirect_pc_i = 64'h7000;
    sample(); next_cycle();
    flush_rt_i = 1'b0; icache_fill_i = 1'b0;
    sample(); chk("t6_addr", 72'(icache_addr_o), 72'(64'h7000)); chk("t6_run", 72'(dbg_state_o), 72'(0));
    next_cycle();

    // Sequential wrap at the top of the address space.
    flush_to(64'hFFFF_FFFF_FFFF_FFE4);
    sample(); chk("wrap_a", 72'(icache_addr_o), 72'(64'hFFFF_FFFF_FFFF_FFE0));
    next_cycle();
    sample(); chk("wrap_b", 72'(icache_addr_o), 72'(64'h0)); chk("wrap_vld", 72'(inst_vld_o), 72'(8'hFE));
    next_cycle();

    // Random traffic, with one mid-run reset.
    for (int c = 0; c < 3000; c++) begin
      reset_n       = (c != 1500);
      flush_rt_i    = ($urandom_range(0, 19) == 0);
      redirect_pc_i = ($urandom_range(0, 7) == 0) ? {56'hFFFF_FFFF_FFFF_FF, 8'($urandom_range(0, 255))}
                                                  : {$urandom, $urandom};
      icache_hit_i  = ($urandom_range(0, 7) != 0);
      inst_q_full_i = ($urandom_range(0, 7) == 0);
      icache_fill_i = ($urandom_range(0, 5) == 0);
      for (int k = 0; k < 8; k++) icache_data_i[32*k +: 32] = rand_word();
      sample();
      next_cycle();
    end

    reset_n = 1'b1;
    idle_inputs();
    repeat (4) begin
      sample();
      next_cycle();
    end
    chk("sb_empty", 72'(exp_q.size()), 72'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
